// File: rtl/reel_rng_bank_pkg.sv
// Shared types and defaults for the reel random-number bank.
// Holds the channel FSM encoding, LFSR defaults and the tick counter width helper.
package reel_rng_bank_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SPIN     = 2'd1,
        STOPPING = 2'd2,
        STOPPED  = 2'd3
    } ch_state_t;

    localparam logic [15:0] DEFAULT_POLY = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic int cnt_width(input int tick);
        return (tick < 2) ? 1 : $clog2(tick);
    endfunction

endpackage

// File: rtl/reel_rng_bank_lfsr_galois.sv
// Free-running Galois LFSR shared by all reel channels.
// A zero seed is replaced by SEED so the register can never lock up at all-zeros.
module lfsr_galois #(
    parameter int                 LFSR_W = 16,
    parameter logic [LFSR_W-1:0]  POLY   = 16'hB400,
    parameter logic [LFSR_W-1:0]  SEED   = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    output logic [LFSR_W-1:0] lfsr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= SEED;
        end else if (seed_load) begin
            lfsr <= (seed_in == '0) ? SEED : seed_in;
        end else begin
            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? POLY : '0);
        end
    end

endmodule

// File: rtl/reel_rng_bank.sv
// Multi-channel reel value generator: one shared LFSR, a sample tick counter,
// and one spin/stop FSM per reel that samples range-limited values on each tick.
module reel_rng_bank
    import reel_rng_bank_pkg::*;
#(
    parameter int                 N_CH   = 3,
    parameter int                 LFSR_W = 16,
    parameter logic [LFSR_W-1:0]  POLY   = DEFAULT_POLY,
    parameter logic [LFSR_W-1:0]  SEED   = DEFAULT_SEED,
    parameter int                 OUT_W  = 4,
    parameter int                 RANGE  = 10,
    parameter int                 TICK   = 2_500_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       en,
    input  logic [N_CH-1:0]       stop_req,
    input  logic                  seed_load,
    input  logic [LFSR_W-1:0]     seed_in,
    output logic [N_CH*OUT_W-1:0] value,
    output logic [N_CH-1:0]       stopped,
    output logic                  tick
);

    localparam int CNT_W = cnt_width(TICK);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK - 1);
    localparam logic [OUT_W:0]   RANGE_LIM = (OUT_W + 1)'(RANGE);

    logic [LFSR_W-1:0] lfsr;
    logic [CNT_W-1:0]  count;
    logic              unused_lfsr_bits;

    lfsr_galois #(
        .LFSR_W (LFSR_W),
        .POLY   (POLY),
        .SEED   (SEED)
    ) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .lfsr      (lfsr)
    );

    // Bits above the channel slices only feed the LFSR itself.
    assign unused_lfsr_bits = ^lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (count == CNT_LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == CNT_LAST);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        ch_state_t        state;
        logic [OUT_W-1:0] val;
        logic             landed;
        logic [OUT_W-1:0] cand;
        logic             take;

        assign cand = lfsr[i*OUT_W +: OUT_W];
        assign take = tick && ({1'b0, cand} < RANGE_LIM);

        // en dropping always wins; a stop arriving on a take cycle lands at once.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state  <= IDLE;
                val    <= '0;
                landed <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (en[i]) begin
                            state <= SPIN;
                        end
                    end
                    SPIN: begin
                        if (!en[i]) begin
                            state <= IDLE;
                        end else if (stop_req[i]) begin
                            if (take) begin
                                val    <= cand;
                                landed <= 1'b1;
                                state  <= STOPPED;
                            end else begin
                                state <= STOPPING;
                            end
                        end else if (take) begin
                            val <= cand;
                        end
                    end
                    STOPPING: begin
                        if (!en[i]) begin
                            state <= IDLE;
                        end else if (take) begin
                            val    <= cand;
                            landed <= 1'b1;
                            state  <= STOPPED;
                        end
                    end
                    STOPPED: begin
                        if (!en[i]) begin
                            state  <= IDLE;
                            landed <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end

        assign value[i*OUT_W +: OUT_W] = val;
        assign stopped[i]              = landed;
    end

endmodule

// File: tb/tb_reel_rng_bank.sv
// Self-checking bench for reel_rng_bank with TICK=4: directed scenarios plus
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_reel_rng_bank;

    localparam int          N_CH  = 3;
    localparam int          OUT_W = 4;
    localparam int          RANGE = 10;
    localparam int          TICK  = 4;
    localparam logic [15:0] POLY  = 16'hB400;
    localparam logic [15:0] SEED  = 16'hACE1;

    localparam int M_IDLE     = 0;
    localparam int M_SPIN     = 1;
    localparam int M_STOPPING = 2;
    localparam int M_STOPPED  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  en;
    logic [2:0]  stop_req;
    logic        seed_load;
    logic [15:0] seed_in;
    logic [11:0] value;
    logic [2:0]  stopped;
    logic        tick;

    int checks   = 0;
    int failures = 0;

    int m_lfsr;
    int m_count;
    int m_st[N_CH];
    int m_val[N_CH];
    int m_stp[N_CH];

    reel_rng_bank #(
        .N_CH   (N_CH),
        .LFSR_W (16),
        .POLY   (POLY),
        .SEED   (SEED),
        .OUT_W  (OUT_W),
        .RANGE  (RANGE),
        .TICK   (TICK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .stop_req  (stop_req),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .value     (value),
        .stopped   (stopped),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lfsrStep(input int x);
        return (x >> 1) ^ (((x & 1) != 0) ? int'(POLY) : 0);
    endfunction

    task automatic modelReset();
        m_lfsr  = int'(SEED);
        m_count = 0;
        for (int c = 0; c < N_CH; c++) begin
            m_st[c]  = M_IDLE;
            m_val[c] = 0;
            m_stp[c] = 0;
        end
    endtask

    task automatic compareAll();
        logic [11:0] exp_val;
        logic [2:0]  exp_stp;
        for (int c = 0; c < N_CH; c++) begin
            exp_val[c*OUT_W +: OUT_W] = 4'(m_val[c]);
            exp_stp[c]                = (m_stp[c] != 0);
        end
        checkOutput("value", 32'(value), 32'(exp_val));
        checkOutput("stopped", 32'(stopped), 32'(exp_stp));
        checkOutput("tick", 32'(tick), 32'(m_count == TICK - 1));
        checkOutput("lfsr", 32'(dut.lfsr), 32'(m_lfsr));
    endtask

    // One clock: the model decides the next state from the pre-edge values.
    task automatic applyStimulus(input logic [2:0] e, input logic [2:0] s,
                                 input logic sl, input logic [15:0] si);
        bit tk;
        int cand;
        bit ok;
        en        = e;
        stop_req  = s;
        seed_load = sl;
        seed_in   = si;
        tk = (m_count == TICK - 1);
        for (int c = 0; c < N_CH; c++) begin
            cand = (m_lfsr >> (c * OUT_W)) & 15;
            ok   = tk && (cand < RANGE);
            if (m_st[c] == M_IDLE) begin
                if (e[c]) m_st[c] = M_SPIN;
            end else if (m_st[c] == M_STOPPED) begin
                if (!e[c]) begin
                    m_st[c]  = M_IDLE;
                    m_stp[c] = 0;
                end
            end else if (!e[c]) begin
                m_st[c] = M_IDLE;
            end else begin
                if (m_st[c] == M_SPIN && s[c]) m_st[c] = M_STOPPING;
                if (ok) m_val[c] = cand;
                if (ok && m_st[c] == M_STOPPING) begin
                    m_stp[c] = 1;
                    m_st[c]  = M_STOPPED;
                end
            end
        end
        m_lfsr  = sl ? ((si == 16'h0) ? int'(SEED) : int'(si)) : lfsrStep(m_lfsr);
        m_count = (m_count + 1) % TICK;
        @(posedge clk);
        #1;
        compareAll();
    endtask

    task automatic doReset();
        rst = 1'b1;
        #1;
        modelReset();
        compareAll();
        @(negedge clk);
        rst       = 1'b0;
        en        = '0;
        stop_req  = '0;
        seed_load = 1'b0;
        seed_in   = '0;
    endtask

    task automatic runUntilCount(input int target, input logic [2:0] e);
        for (int k = 0; k < 2 * TICK && m_count != target; k++) begin
            applyStimulus(e, 3'b000, 1'b0, 16'h0);
        end
    endtask

    initial begin
        logic [3:0]  held;
        logic [2:0]  re;
        logic [2:0]  rs;
        logic        rl;
        logic [15:0] rv;
        int          waited;

        en        = '0;
        stop_req  = '0;
        seed_load = 1'b0;
        seed_in   = '0;
        doReset();

        applyStimulus(3'b000, 3'b000, 1'b0, 16'h0);
        checkOutput("lfsr_step1", 32'(dut.lfsr), 32'h0000E270);
        applyStimulus(3'b000, 3'b000, 1'b0, 16'h0);
        checkOutput("lfsr_step2", 32'(dut.lfsr), 32'h00007138);

        applyStimulus(3'b000, 3'b000, 1'b1, 16'h0000);
        checkOutput("seed_zero", 32'(dut.lfsr), 32'h0000ACE1);
        applyStimulus(3'b000, 3'b000, 1'b1, 16'h0001);
        checkOutput("seed_one", 32'(dut.lfsr), 32'h00000001);

        // Rejection: candidate 4'hC on channel 0 is held, a later 4'h7 is taken.
        applyStimulus(3'b111, 3'b000, 1'b0, 16'h0);
        runUntilCount(TICK - 2, 3'b111);
        applyStimulus(3'b111, 3'b000, 1'b1, 16'h000C);
        held = 4'(m_val[0]);
        applyStimulus(3'b111, 3'b000, 1'b0, 16'h0);
        checkOutput("reject_hold", 32'(value[3:0]), 32'(held));
        checkOutput("reject_ch1", 32'(value[7:4]), 32'h0);
        runUntilCount(TICK - 2, 3'b111);
        applyStimulus(3'b111, 3'b000, 1'b1, 16'h0007);
        applyStimulus(3'b111, 3'b000, 1'b0, 16'h0);
        checkOutput("accept_7", 32'(value[3:0]), 32'h7);

        // Stop channel 1 mid-period, then it must stay frozen.
        runUntilCount(1, 3'b111);
        applyStimulus(3'b111, 3'b010, 1'b0, 16'h0);
        waited = 0;
        while (!stopped[1] && waited < 12 * TICK) begin
            applyStimulus(3'b111, 3'b000, 1'b0, 16'h0);
            waited++;
        end
        checkOutput("stop_land", 32'(stopped[1]), 32'h1);
        held = value[7:4];
        for (int k = 0; k < 3 * TICK; k++) applyStimulus(3'b111, 3'b000, 1'b0, 16'h0);
        checkOutput("stop_frozen", 32'(value[7:4]), 32'(held));
        checkOutput("stop_still", 32'(stopped[1]), 32'h1);

        // Abort channel 2 before its tick, then re-enable it.
        runUntilCount(0, 3'b111);
        applyStimulus(3'b111, 3'b100, 1'b0, 16'h0);
        for (int k = 0; k < 2 * TICK; k++) applyStimulus(3'b011, 3'b000, 1'b0, 16'h0);
        checkOutput("abort_nostop", 32'(stopped[2]), 32'h0);
        for (int k = 0; k < 3 * TICK; k++) applyStimulus(3'b111, 3'b000, 1'b0, 16'h0);
        checkOutput("abort_resume", 32'(stopped[2]), 32'h0);

        // Async reset while channel 0 is STOPPING.
        applyStimulus(3'b000, 3'b000, 1'b0, 16'h0);
        applyStimulus(3'b111, 3'b000, 1'b0, 16'h0);
        runUntilCount(0, 3'b111);
        applyStimulus(3'b111, 3'b001, 1'b0, 16'h0);
        #2;
        doReset();
        checkOutput("rst_value", 32'(value), 32'h0);
        checkOutput("rst_stopped", 32'(stopped), 32'h0);
        for (int k = 0; k < 3 * TICK; k++) applyStimulus(3'b111, 3'b000, 1'b0, 16'h0);
        checkOutput("rst_nolanding", 32'(stopped), 32'h0);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < N_CH; c++) begin
                re[c] = ($urandom_range(7) != 0);
                rs[c] = ($urandom_range(7) == 0);
            end
            rl = ($urandom_range(39) == 0);
            rv = ($urandom_range(3) == 0) ? 16'h0 : 16'($urandom);
            applyStimulus(re, rs, rl, rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
